flag_ctrl: RTL

FLAG_CTRL -- requirements
Module: flag_ctrl

---
 rtl/flag_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/flag_ctrl.sv
// ============================================================================
// flag_ctrl
// ----------------------------------------------------------------------------
// Purpose:
//   Drives an external set/clear flag towards a requested level and watches
//   the flag's feedback until it matches. It issues a one-cycle set or clear
//   strobe, then waits up to TIMEOUT cycles for the flag to follow. It
//   finishes with a one-cycle done pulse or a one-cycle err pulse. After
//   either outcome the block stays busy for GAP idle cycles before it takes
//   another request. A timeout also latches err_sticky, which stays set
//   until err_clr is asserted.
//
// Parameters:
//   TIMEOUT  maximum number of WAIT cycles for the flag to match (1..255)
//   GAP      idle cycles after DONE/ERR before the next request (0..15)
//
// Ports:
//   clk         in   single clock, rising-edge active
//   rst_n       in   synchronous active-low reset
//   req_valid   in   request present
//   req_level   in   requested flag level (1 = set, 0 = clear)
//   req_ready   out  block can accept a request this cycle
//   flag_in     in   current state of the controlled flag (feedback)
//   set_pulse   out  one-cycle set strobe
//   clr_pulse   out  one-cycle clear strobe
//   done        out  one-cycle pulse: flag reached the target
//   err         out  one-cycle pulse: flag did not reach the target in time
//   err_sticky  out  latched timeout indicator
//   err_clr     in   clears err_sticky
// ============================================================================
module flag_ctrl #(
    parameter int TIMEOUT = 8,
    parameter int GAP     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    input  logic req_level,
    output logic req_ready,
    input  logic flag_in,
    output logic set_pulse,
    output logic clr_pulse,
    output logic done,
    output logic err,
    output logic err_sticky,
    input  logic err_clr
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PULSE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4,
        GAPW  = 3'd5
    } state_t;

    // Terminal counter values. WAIT_LAST is the last WAIT cycle allowed
    // before a timeout. When GAP is 0, GAPW is never entered, so the value
    // of GAP_LAST does not matter.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [3:0] GAP_LAST  = 4'(GAP - 1);
    localparam bit         HAS_GAP   = (GAP > 0);

    state_t     state_q,      state_d;
    logic       target_q,     target_d;
    logic [7:0] wait_cnt_q,   wait_cnt_d;
    logic [3:0] gap_cnt_q,    gap_cnt_d;
    logic       err_sticky_q, err_sticky_d;

    // Ready depends only on state, plus rst_n. A reset edge therefore never
    // coincides with an acceptance.
    assign req_ready  = (state_q == IDLE) && rst_n;
    assign err_sticky = err_sticky_q;

    // Next-state and output decode
    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        wait_cnt_d = wait_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        set_pulse  = 1'b0;
        clr_pulse  = 1'b0;
        done       = 1'b0;
        err        = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    // The target is latched at acceptance. If the flag
                    // already matches, no strobe is needed.
                    target_d = req_level;
                    if (flag_in == req_level) begin
                        state_d = DONE;
                    end else begin
                        state_d = PULSE;
                    end
                end
            end

            PULSE: begin
                set_pulse  = target_q;
                clr_pulse  = ~target_q;
                wait_cnt_d = 8'd0;
                state_d    = WAIT;
            end

            WAIT: begin
                // A match wins over a timeout, even in the last allowed
                // cycle. The counter stops at WAIT_LAST and never wraps.
                if (flag_in == target_q) begin
                    state_d = DONE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end

            DONE: begin
                done      = 1'b1;
                gap_cnt_d = 4'd0;
                state_d   = HAS_GAP ? GAPW : IDLE;
            end

            ERR: begin
                err       = 1'b1;
                gap_cnt_d = 4'd0;
                state_d   = HAS_GAP ? GAPW : IDLE;
            end

            GAPW: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sticky error: leaving ERR sets it, and err_clr clears it. When both
    // happen on the same edge, set wins.
    always_comb begin
        err_sticky_d = err_sticky_q;
        if (state_q == ERR) begin
            err_sticky_d = 1'b1;
        end else if (err_clr) begin
            err_sticky_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            target_q     <= 1'b0;
            wait_cnt_q   <= 8'd0;
            gap_cnt_q    <= 4'd0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            wait_cnt_q   <= wait_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            err_sticky_q <= err_sticky_d;
        end
    end

endmodule
